// File: rtl/multdiv.sv
// Iterative 32-bit signed multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, fixed 34-cycle latency (2 cycles for divide-by-zero).
module multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int WW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             is_mult_q, is_mult_d;
    logic             neg_q, neg_d;
    logic [WIDTH:0]   mag_q, mag_d;
    logic [WW-1:0]    work_q, work_d;

    logic             start;
    logic [WIDTH:0]   a_mag, b_mag, add_sum, rem_shift;
    logic [WIDTH+1:0] rem_diff;
    logic [WW-1:0]    prod;
    logic [WIDTH-1:0] quot;

    // Magnitudes need WIDTH+1 bits so that |0x80000000| = 2^31 is representable.
    assign a_mag = data_operandA[WIDTH-1] ? ({(WIDTH+1){1'b0}} - {1'b1, data_operandA})
                                          : {1'b0, data_operandA};
    assign b_mag = data_operandB[WIDTH-1] ? ({(WIDTH+1){1'b0}} - {1'b1, data_operandB})
                                          : {1'b0, data_operandB};
    assign start = (ctrl_MULT | ctrl_DIV) && (state_q == IDLE || state_q == DONE);

    // work_q holds {upper partial product, multiplier} or {remainder, quotient}.
    assign add_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? mag_q : {(WIDTH+1){1'b0}});
    assign rem_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign rem_diff  = {1'b0, rem_shift} - {1'b0, mag_q};
    assign prod      = neg_q ? ({WW{1'b0}} - work_q) : work_q;
    assign quot      = neg_q ? ({WIDTH{1'b0}} - work_q[WIDTH-1:0]) : work_q[WIDTH-1:0];

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        exc_d     = exc_q;
        is_mult_d = is_mult_q;
        neg_d     = neg_q;
        mag_d     = mag_q;
        work_d    = work_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    cnt_d     = '0;
                    is_mult_d = ctrl_MULT;
                    neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    if (ctrl_MULT) begin
                        mag_d   = a_mag;
                        work_d  = {{(WIDTH+1){1'b0}}, b_mag[WIDTH-1:0]};
                        state_d = RUN;
                    end else begin
                        mag_d   = b_mag;
                        work_d  = {{(WIDTH+1){1'b0}}, a_mag[WIDTH-1:0]};
                        state_d = (data_operandB == '0) ? FINAL : RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_mult_q)
                    work_d = {1'b0, add_sum, work_q[WIDTH-1:1]};
                else if (rem_diff[WIDTH+1])
                    work_d = {rem_shift, work_q[WIDTH-2:0], 1'b0};
                else
                    work_d = {rem_diff[WIDTH:0], work_q[WIDTH-2:0], 1'b1};
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = FINAL;
            end
            FINAL: begin
                state_d = DONE;
                if (is_mult_q) begin
                    result_d = prod[WIDTH-1:0];
                    exc_d    = prod[WW-1:WIDTH] != {(WIDTH+1){prod[WIDTH-1]}};
                end else if (mag_q == '0) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                end else begin
                    // A positive quotient of 2^31 only arises from 0x80000000 / -1.
                    result_d = quot;
                    exc_d    = work_q[WIDTH-1] & ~neg_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    // NOTE: datapath registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clock) begin
        is_mult_q <= is_mult_d;
        neg_q     <= neg_d;
        mag_q     <= mag_d;
        work_q    <= work_d;
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN) || (state_q == FINAL);

endmodule
